// File: rtl/iir1_mc_pkg.sv
// Shared types and helpers for the multi-channel first-order IIR filter.
package iir1_mc_pkg;

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    localparam logic COEF_SEL_A = 1'b0;
    localparam logic COEF_SEL_B = 1'b1;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iir1_mc_coef_bank.sv
// Per-channel A/B coefficient register file with one write port and an
// asynchronous read port used at sample accept.
module iir1_mc_coef_bank
    import iir1_mc_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int N_CH   = 4,
    parameter int A_INIT = 2,
    parameter int B_INIT = 3,
    localparam int CH_W  = ch_w(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     sel,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic [CH_W-1:0]          rd_ch,
    output logic signed [COEF_W-1:0] rd_a,
    output logic signed [COEF_W-1:0] rd_b
);

    // Storage is sized to the full index range so any index is legal;
    // entries at or above N_CH are never written and never read out.
    localparam int DEPTH = 2 ** CH_W;

    logic signed [COEF_W-1:0] a_mem [DEPTH];
    logic signed [COEF_W-1:0] b_mem [DEPTH];
    logic                     wr_ok;
    logic                     rd_ok;

    assign wr_ok = {1'b0, wr_ch} < (CH_W+1)'(N_CH);
    assign rd_ok = {1'b0, rd_ch} < (CH_W+1)'(N_CH);

    // Coefficient registers: reset to the init values, in-range writes only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_mem[i] <= COEF_W'(A_INIT);
                b_mem[i] <= COEF_W'(B_INIT);
            end
        end else if (we && wr_ok) begin
            if (sel == COEF_SEL_A) a_mem[wr_ch] <= wr_data;
            else                   b_mem[wr_ch] <= wr_data;
        end
    end

    // Out-of-range channels read as zero coefficients.
    always_comb begin
        rd_a = rd_ok ? a_mem[rd_ch] : '0;
        rd_b = rd_ok ? b_mem[rd_ch] : '0;
    end

endmodule

// File: rtl/iir1_mc_filter.sv
// Time-multiplexed multi-channel IIR filter y = A*y[n-1] + B*x[n] with
// runtime coefficients, fixed-point scaling and valid/ready on both sides.
// Build option: define IIR1_MC_SAT_EN to saturate instead of wrap, which
// also adds the sticky sat_flag output.
module iir1_mc_filter
    import iir1_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 32,
    parameter int COEF_W = 16,
    parameter int FRAC   = 0,
    parameter int N_CH   = 4,
    parameter int A_INIT = 2,
    parameter int B_INIT = 3,
    localparam int CH_W  = ch_w(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [OUT_W-1:0]  out_y,
    input  logic                     coef_we,
    input  logic                     coef_sel,
    input  logic [CH_W-1:0]          coef_ch,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     state_clr
`ifdef IIR1_MC_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int PW    = COEF_W + OUT_W;  // product width
    localparam int SW    = PW + 1;          // sum width, one guard bit
    localparam int DEPTH = 2 ** CH_W;

    state_t                     state, nxt;
    logic                       accept;
    logic                       in_ok;
    logic signed [COEF_W-1:0]   coef_a, coef_b;

    logic signed [DATA_W-1:0]   x_r;
    logic [CH_W-1:0]            ch_r;
    logic                       ok_r;
    logic signed [OUT_W-1:0]    yp_r;
    logic signed [COEF_W-1:0]   a_r, b_r;
    logic signed [PW-1:0]       pa, pb;
    logic signed [SW-1:0]       s;
    logic signed [OUT_W-1:0]    res;
    logic signed [OUT_W-1:0]    y_mem [DEPTH];

    assign in_ready = (state == IDLE) || (state == OUT && out_ready);
    assign accept   = in_valid && in_ready;
    assign in_ok    = {1'b0, in_ch} < (CH_W+1)'(N_CH);

    iir1_mc_coef_bank #(
        .COEF_W (COEF_W),
        .N_CH   (N_CH),
        .A_INIT (A_INIT),
        .B_INIT (B_INIT)
    ) u_coef (
        .clk     (clk),
        .reset   (reset),
        .we      (coef_we),
        .sel     (coef_sel),
        .wr_ch   (coef_ch),
        .wr_data (coef_data),
        .rd_ch   (in_ch),
        .rd_a    (coef_a),
        .rd_b    (coef_b)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state: one sample walks MUL -> ACC -> OUT; OUT may chain an accept.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = MUL;
            MUL:     nxt = ACC;
            ACC:     nxt = OUT;
            OUT:     if (out_ready) nxt = in_valid ? MUL : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Accept capture and registered multiply; the captured coefficients and
    // pre-clear history stay with the sample regardless of later writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r  <= '0;
            ch_r <= '0;
            ok_r <= 1'b0;
            yp_r <= '0;
            a_r  <= '0;
            b_r  <= '0;
            pa   <= '0;
            pb   <= '0;
        end else begin
            if (accept) begin
                x_r  <= in_x;
                ch_r <= in_ch;
                ok_r <= in_ok;
                yp_r <= in_ok ? y_mem[in_ch] : '0;
                a_r  <= coef_a;
                b_r  <= coef_b;
            end
            if (state == MUL) begin
                pa <= PW'(a_r) * PW'(yp_r);
                pb <= PW'(b_r) * PW'(x_r);
            end
        end
    end

    // Accumulate, scale (floor via arithmetic shift) and reduce to OUT_W.
`ifdef IIR1_MC_SAT_EN
    localparam logic signed [SW-1:0] YMAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] YMIN = ~YMAX;
    logic signed [SW-1:0] r;
    logic                 clip;

    always_comb begin
        s    = SW'(pa) + SW'(pb);
        r    = s >>> FRAC;
        clip = 1'b0;
        res  = r[OUT_W-1:0];
        if (r > YMAX) begin
            res  = YMAX[OUT_W-1:0];
            clip = 1'b1;
        end else if (r < YMIN) begin
            res  = YMIN[OUT_W-1:0];
            clip = 1'b1;
        end
    end

    // Sticky clip indicator, cleared together with the channel state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      sat_flag <= 1'b0;
        else if (state_clr)             sat_flag <= 1'b0;
        else if (state == ACC && clip)  sat_flag <= 1'b1;
    end
`else
    always_comb begin
        s   = SW'(pa) + SW'(pb);
        res = OUT_W'(s >>> FRAC);
    end
`endif

    // Output register: loaded in ACC, held until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_ch    <= '0;
        end else if (state == ACC) begin
            out_valid <= 1'b1;
            out_y     <= res;
            out_ch    <= ch_r;
        end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Channel history: clear beats write-back; invalid channels never write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || state_clr) begin
            for (int i = 0; i < DEPTH; i++) y_mem[i] <= '0;
        end else if (state == ACC && ok_r) begin
            y_mem[ch_r] <= res;
        end
    end

endmodule
